// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package ifu_pkg;

   // AXI read-response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Default first fetch address after reset
   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

   // Prefetch queue entry at the default 32-bit widths; the top packs the
   // same {pc, inst, err} field order for any ADDR_W/DATA_W.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } ifu_entry_t;

   // Fetch control states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_AR_WAIT = 2'd1,
      ST_R_WAIT  = 2'd2,
      ST_HALT    = 2'd3
   } ifu_state_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch queue: power-of-two ring buffer with flush. Head is read
// combinationally so a push on edge n is visible right after edge n.
module ifu_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next-state for pointers, occupancy and storage; flush wins over push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; outputs are masked while empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: one AXI-lite read in flight, results
// queued for decode. Redirect flushes the queue and drops an in-flight read.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_err,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   output logic              rready
);
   localparam int                EW   = ADDR_W + DATA_W + 1;
   localparam int                CW   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

   ifu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              drop_q, drop_d;
   logic              rready_q, rready_d;

   logic              fifo_push, fifo_pop, fifo_flush;
   logic [EW-1:0]     fifo_wdata, fifo_head;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              r_hs, room;

   ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign arvalid    = (state_q == ST_AR_WAIT);
   assign araddr     = araddr_q;
   assign rready     = rready_q;
   assign out_valid  = !fifo_empty;
   assign out_pc     = fifo_empty ? '0   : fifo_head[EW-1 -: ADDR_W];
   assign out_inst   = fifo_empty ? '0   : fifo_head[DATA_W:1];
   assign out_err    = fifo_empty ? 1'b0 : fifo_head[0];
   assign fifo_pop   = out_valid && out_ready;
   assign fifo_wdata = {araddr_q, rdata, (rresp != RESP_OKAY)};
   // Only a response to our own issued read is a real handshake
   assign r_hs       = (state_q == ST_R_WAIT) && rvalid && rready_q;
   // Room for another entry once the current response lands
   assign room       = (fifo_count < CW'(DEPTH - 1)) || fifo_pop;

   // Fetch control: redirect first, then the normal issue/response flow
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      araddr_d   = araddr_q;
      drop_d     = drop_q;
      rready_d   = 1'b1;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      if (redirect_valid) begin
         fifo_flush = 1'b1;
         fetch_pc_d = redirect_pc;
         case (state_q)
            // arvalid must stay up; the read will be discarded later
            ST_AR_WAIT: begin
               drop_d = 1'b1;
               if (arready) state_d = ST_R_WAIT;
            end
            ST_R_WAIT: begin
               if (r_hs) begin
                  drop_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  drop_d = 1'b1;
               end
            end
            default: begin
               drop_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_full) begin
                  state_d  = ST_AR_WAIT;
                  araddr_d = fetch_pc_q;
               end
            end
            ST_AR_WAIT: begin
               if (arready) begin
                  state_d = ST_R_WAIT;
                  // a read already marked for dropping must not move the new pc
                  if (!drop_q) fetch_pc_d = fetch_pc_q + STEP;
               end
            end
            ST_R_WAIT: begin
               if (r_hs) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     fifo_push = 1'b1;
                     if (rresp != RESP_OKAY) begin
                        state_d = ST_HALT;
                     end else if (room) begin
                        // chain straight into the next read for 2-cycle throughput
                        state_d  = ST_AR_WAIT;
                        araddr_d = fetch_pc_q;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         araddr_q   <= '0;
         drop_q     <= 1'b0;
         rready_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         araddr_q   <= araddr_d;
         drop_q     <= drop_d;
         rready_q   <= rready_d;
      end
   end

endmodule
